// File: rtl/cmp_mon_pkg.sv
// Shared types for the comparator threshold monitor: FSM states, sample
// classes and the one-hot result classifier.
package cmp_mon_pkg;

  typedef enum logic {
    ST_LOW,
    ST_HIGH
  } state_t;

  typedef enum logic [1:0] {
    CLS_ABOVE,
    CLS_BELOW,
    CLS_NEUTRAL,
    CLS_BAD
  } cls_t;

  // An invalid cycle reports NEUTRAL; callers gate on valid before acting.
  function automatic cls_t classify(input logic valid, input logic lt,
                                    input logic eq, input logic gt,
                                    input logic incl_eq);
    logic [1:0] ones;
    ones = 2'(lt) + 2'(eq) + 2'(gt);
    if (!valid)                   return CLS_NEUTRAL;
    if (ones != 2'd1)             return CLS_BAD;
    if (gt || (incl_eq && eq))    return CLS_ABOVE;
    if (lt)                       return CLS_BELOW;
    return CLS_NEUTRAL;
  endfunction

endpackage

// File: rtl/cmp_run_counter.sv
// Saturating run-length counter; hit reports whether the incremented count
// would reach the target, so the FSM can transition on the completing sample.
module cmp_run_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] target,
  output logic             hit
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] bump;

  always_comb begin
    bump = (count == '1) ? count : count + 1'b1;
    hit  = (bump >= target);
  end

  always_ff @(posedge clk) begin
    if (rst || clr)  count <= '0;
    else if (inc)    count <= bump;
  end

endmodule

// File: rtl/cmp_threshold_monitor.sv
// Debounces the comparator's lt/eq/gt stream into a hysteretic alarm with
// rise/fall pulses, a wrapping rise counter and a sticky malformed-input flag.
module cmp_threshold_monitor
  import cmp_mon_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int EVT_W   = 16,
  parameter int INCL_EQ = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic [CNT_W-1:0] set_count,
  input  logic [CNT_W-1:0] clr_count,
  input  logic             ack,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic [EVT_W-1:0] evt_count,
  output logic             err_sticky
);

  state_t           state_q, state_d;
  cls_t             cls;
  logic             run_inc, run_clr, run_hit;
  logic             rise_d, fall_d;
  logic [CNT_W-1:0] eff_set, eff_clr, target;

  assign cls     = classify(in_valid, cmp_lt, cmp_eq, cmp_gt, INCL_EQ != 0);
  assign eff_set = (set_count == '0) ? CNT_W'(1) : set_count;
  assign eff_clr = (clr_count == '0) ? CNT_W'(1) : clr_count;
  assign target  = (state_q == ST_LOW) ? eff_set : eff_clr;

  cmp_run_counter #(.CNT_W(CNT_W)) u_run (
    .clk    (clk),
    .rst    (rst),
    .inc    (run_inc),
    .clr    (run_clr),
    .target (target),
    .hit    (run_hit)
  );

  always_comb begin
    state_d = state_q;
    run_inc = 1'b0;
    run_clr = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_LOW: begin
          case (cls)
            CLS_ABOVE: begin
              if (run_hit) begin
                state_d = ST_HIGH;
                run_clr = 1'b1;
                rise_d  = 1'b1;
              end else begin
                run_inc = 1'b1;
              end
            end
            CLS_BELOW, CLS_NEUTRAL: run_clr = 1'b1;
            default: ;
          endcase
        end
        ST_HIGH: begin
          case (cls)
            CLS_BELOW: begin
              if (run_hit) begin
                state_d = ST_LOW;
                run_clr = 1'b1;
                fall_d  = 1'b1;
              end else begin
                run_inc = 1'b1;
              end
            end
            CLS_ABOVE: run_clr = 1'b1;
            // Neutral holds the run: this is the hysteresis band.
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOW;
      alarm_rise <= 1'b0;
      alarm_fall <= 1'b0;
      evt_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      alarm_rise <= rise_d;
      alarm_fall <= fall_d;
      if (rise_d) evt_count <= evt_count + EVT_W'(1);
      // A malformed sample wins over a simultaneous ack.
      if (in_valid && cls == CLS_BAD) err_sticky <= 1'b1;
      else if (ack)                   err_sticky <= 1'b0;
    end
  end

  assign alarm = (state_q == ST_HIGH);

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Scoreboard bench: the driver runs a behavioural model per cycle and queues
// expected outputs; a negedge monitor pops and compares against the DUT.
module tb_cmp_threshold_monitor;

  localparam int CNT_W   = 4;
  localparam int EVT_W   = 3;
  localparam int INCL_EQ = 0;
  localparam int RUN_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, cmp_lt, cmp_eq, cmp_gt, ack;
  logic [CNT_W-1:0] set_count, clr_count;
  logic             alarm, alarm_rise, alarm_fall, err_sticky;
  logic [EVT_W-1:0] evt_count;

  cmp_threshold_monitor #(.CNT_W(CNT_W), .EVT_W(EVT_W), .INCL_EQ(INCL_EQ)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .cmp_gt(cmp_gt), .set_count(set_count), .clr_count(clr_count), .ack(ack),
    .alarm(alarm), .alarm_rise(alarm_rise), .alarm_fall(alarm_fall),
    .evt_count(evt_count), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit alarm, rise, fall, err;
    int evt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit m_high, m_err;
  int m_run, m_evt;

  function automatic exp_t model(bit r, bit v, bit l, bit e, bit g, bit a, int sc, int cc);
    exp_t x;
    int es, ec, n;
    x.rise = 0; x.fall = 0;
    if (r) begin
      m_high = 0; m_err = 0; m_run = 0; m_evt = 0;
    end else begin
      if (v && (int'(l) + int'(e) + int'(g) != 1)) m_err = 1;
      else if (a)                                  m_err = 0;
      if (v && (int'(l) + int'(e) + int'(g) == 1)) begin
        es = (sc == 0) ? 1 : sc;
        ec = (cc == 0) ? 1 : cc;
        n  = (m_run + 1 > RUN_MAX) ? RUN_MAX : m_run + 1;
        if (!m_high) begin
          if (g || (INCL_EQ != 0 && e)) begin
            if (n >= es) begin
              m_high = 1; m_run = 0; x.rise = 1;
              m_evt = (m_evt + 1) % (1 << EVT_W);
            end else m_run = n;
          end else m_run = 0;
        end else begin
          if (l) begin
            if (n >= ec) begin
              m_high = 0; m_run = 0; x.fall = 1;
            end else m_run = n;
          end else if (g || (INCL_EQ != 0 && e)) m_run = 0;
        end
      end
    end
    x.alarm = m_high; x.err = m_err; x.evt = m_evt;
    return x;
  endfunction

  task automatic step(input bit r, input bit v, input bit l, input bit e,
                      input bit g, input bit a);
    rst = r; in_valid = v; cmp_lt = l; cmp_eq = e; cmp_gt = g; ack = a;
    @(posedge clk);
    q.push_back(model(r, v, l, e, g, a, int'(set_count), int'(clr_count)));
    #1;
  endtask

  task automatic gt_s(); step(0, 1, 0, 0, 1, 0); endtask
  task automatic lt_s(); step(0, 1, 1, 0, 0, 0); endtask
  task automatic eq_s(); step(0, 1, 0, 1, 0, 0); endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (alarm !== x.alarm || alarm_rise !== x.rise || alarm_fall !== x.fall ||
          err_sticky !== x.err || int'(evt_count) != x.evt) begin
        errors++;
        $display("FAIL outputs t=%0t got alarm=%b rise=%b fall=%b evt=%0d err=%b want alarm=%b rise=%b fall=%b evt=%0d err=%b",
                 $time, alarm, alarm_rise, alarm_fall, evt_count, err_sticky,
                 x.alarm, x.rise, x.fall, x.evt, x.err);
      end
    end
  end

  initial begin
    int lim;
    set_count = 3; clr_count = 2;
    repeat (2) step(1, 0, 0, 0, 0, 0);
    // gt x3 raises; lt x2 drops
    gt_s(); gt_s(); gt_s();
    lt_s(); lt_s();
    // interrupted run: no alarm
    gt_s(); gt_s(); lt_s(); gt_s(); gt_s(); lt_s();
    // hysteresis band in HIGH
    gt_s(); gt_s(); gt_s();
    lt_s(); eq_s(); eq_s(); lt_s();
    // malformed, ack, ack plus malformed
    gt_s();
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    gt_s(); gt_s();
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    // back-to-back with zero thresholds
    set_count = 0; clr_count = 0;
    gt_s(); lt_s(); gt_s();
    // wrap evt_count, then reset while HIGH
    repeat (9) begin gt_s(); lt_s(); end
    gt_s();
    step(1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit v, l, e, g;
      int k;
      if ($urandom_range(0, 19) == 0) set_count = CNT_W'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) clr_count = CNT_W'($urandom_range(0, 4));
      v = ($urandom_range(0, 9) < 8);
      k = $urandom_range(0, 19);
      l = 0; e = 0; g = 0;
      if (k == 0) begin
        l = 1'($urandom); e = 1'($urandom); g = 1'($urandom);
        if (int'(l) + int'(e) + int'(g) == 1) begin l = 0; e = 0; g = 0; end
      end else if (k < 8)  l = 1;
      else if (k < 11)     e = 1;
      else                 g = 1;
      step($urandom_range(0, 99) == 0, v, l, e, g, $urandom_range(0, 9) == 0);
    end
    lim = 0;
    while (q.size() > 0 && lim < 10) begin @(negedge clk); lim++; end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_threshold_monitor.md
# cmp_threshold_monitor

Sequential monitor placed directly downstream of the 16-bit magnitude comparator. Each cycle it may accept one comparison result (sample vs. threshold, one-hot lt/eq/gt). It debounces the result stream with programmable run lengths and drives a hysteretic alarm plus transition pulses and an event counter. It turns the comparator's instantaneous verdict into a stable, glitch-free status for control logic.

## Interface
Parameters:
- CNT_W, default 4: width of the run-length counters and the set/clear thresholds.
- EVT_W, default 16: width of the alarm event counter.
- INCL_EQ, default 0: when 1, an eq result counts as "above" in addition to gt.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the comparison result is valid this cycle.
- cmp_lt  in  1  sample < threshold.
- cmp_eq  in  1  sample == threshold.
- cmp_gt  in  1  sample > threshold.
- set_count  in  CNT_W  consecutive "above" samples required to raise the alarm; 0 is treated as 1.
- clr_count  in  CNT_W  consecutive lt samples required to drop the alarm; 0 is treated as 1.
- ack  in  1  clears err_sticky.
- alarm  out  1  debounced alarm level.
- alarm_rise  out  1  one-cycle pulse when the alarm rises.
- alarm_fall  out  1  one-cycle pulse when the alarm falls.
- evt_count  out  EVT_W  number of alarm rises; wraps modulo 2^EVT_W.
- err_sticky  out  1  set by a malformed (non-one-hot) valid sample.

## Operation
- A sample is classified only when in_valid=1 and exactly one of lt/eq/gt is high.
  - above = gt, or (INCL_EQ and eq).
  - below = lt.
  - Otherwise the sample is neutral.
- A malformed valid sample (zero or multiple flags high):
  - sets err_sticky;
  - is otherwise ignored, so counters and state are unchanged.
- in_valid=0: nothing changes and no pulses are generated.
- The FSM has states LOW and HIGH. A single run counter run_q is CNT_W bits and saturates at all-ones.
- LOW state:
  - above: run_q+1. If run_q+1 >= eff_set, go to HIGH, clear run_q, pulse alarm_rise, and increment evt_count.
  - below or neutral: run_q cleared.
- HIGH state:
  - below: run_q+1. If run_q+1 >= eff_clr, go to LOW, clear run_q, and pulse alarm_fall.
  - above: run_q cleared.
  - neutral (eq with INCL_EQ=0): run_q held. This is the hysteresis band.
- eff_set / eff_clr = max(set_count, 1) / max(clr_count, 1). Both are sampled every cycle, so a change takes effect on the next valid sample. If a threshold is lowered below the current run_q, the next qualifying sample transitions.
- ack=1 clears err_sticky. If ack and a malformed sample arrive in the same cycle, the set wins.
- alarm = (state == HIGH).

## Timing
- All outputs are registered.
- Latency: the sample that completes a run is accepted at edge N. alarm, the pulse, and evt_count update are visible after edge N; alarm_rise/alarm_fall are high for exactly that cycle.
- Reset values: alarm=0, alarm_rise=0, alarm_fall=0, evt_count=0, err_sticky=0. Internally state=LOW and run_q=0.
- Reset mid-run or during HIGH: everything returns to reset values at the next edge. No alarm_fall pulse is emitted.
- evt_count wraps from 2^EVT_W-1 to 0 with no flag.
- Back-to-back transitions with set=clr=1 are allowed. Example: gt,lt,gt gives rise, fall, rise pulses on consecutive cycles.

## Structure
- Package cmp_mon_pkg holds:
  - the state enum (ST_LOW, ST_HIGH);
  - the sample class enum (CLS_ABOVE, CLS_BELOW, CLS_NEUTRAL, CLS_BAD);
  - a function classify(valid, lt, eq, gt, incl_eq) returning the class.
- One sub-module, cmp_run_counter: a saturating CNT_W counter with inc/clear/hold controls and a ">= target" compare output. The FSM drives it.
- The top level holds the FSM, the output registers, and the error logic.

## Test plan
- Reset then set_count=3: feed gt,gt,gt (valid) -> alarm rises after the 3rd edge, alarm_rise pulses once, evt_count=1.
- set_count=3: feed gt,gt,lt,gt,gt -> no alarm; the run restarts at lt.
- HIGH with clr_count=2, INCL_EQ=0: feed lt,eq,eq,lt -> alarm stays high through the eq samples, then falls on the 2nd lt with one alarm_fall pulse.
- Feed lt+gt both high with in_valid=1 -> err_sticky=1, and run_q and state are unchanged. ack -> err_sticky=0 next cycle. ack plus a malformed sample in the same cycle -> err_sticky stays 1.
- set_count=0, clr_count=0: feed gt,lt,gt -> rise, fall, rise on consecutive cycles, evt_count=2.
- EVT_W=2: produce 5 rises -> evt_count=1. Assert rst while HIGH -> alarm=0, evt_count=0, no fall pulse.
